// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and defaults for the dual-issue instruction prefetch queue.
package inst_fetch_queue_pkg;

  typedef logic [31:0] Word_t;

  typedef struct packed {
    Word_t pc;
    Word_t inst;
  } FetchEntry_t;

  localparam int    FETCH_QUEUE_DEPTH = 8;
  localparam Word_t RESET_PC          = 32'hbfc0_0000;

endpackage

// File: rtl/inst_fetch_queue_ring_buffer.sv
// fetch_ring_buffer: circular entry storage with two write ports (idx, idx+1)
// and two read ports (idx, idx+1); pointer control lives in the parent.
module fetch_ring_buffer
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_QUEUE_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             wr_en_2,
  input  logic [IDX_W-1:0] wr_idx,
  input  FetchEntry_t      wr_entry,
  input  FetchEntry_t      wr_entry_2,
  input  logic [IDX_W-1:0] rd_idx,
  output FetchEntry_t      rd_entry,
  output FetchEntry_t      rd_entry_2
);

  FetchEntry_t      mem_q [DEPTH];
  FetchEntry_t      mem_d [DEPTH];
  logic [IDX_W-1:0] wr_idx_2;
  logic [IDX_W-1:0] rd_idx_2;

  // Index arithmetic wraps naturally in IDX_W bits, so a pair may straddle DEPTH-1 -> 0.
  always_comb begin
    wr_idx_2 = wr_idx + IDX_W'(1);
    mem_d    = mem_q;
    if (wr_en)   mem_d[wr_idx]   = wr_entry;
    if (wr_en_2) mem_d[wr_idx_2] = wr_entry_2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rd_idx_2   = rd_idx + IDX_W'(1);
    rd_entry   = mem_q[rd_idx];
    rd_entry_2 = mem_q[rd_idx_2];
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-issue instruction prefetch queue in front of the SRAM instruction bus.
// Optional FETCH_QUEUE_BYPASS_EN presents a response straight to decode when the queue is empty.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int    DEPTH    = FETCH_QUEUE_DEPTH,
  parameter Word_t RESET_PC = inst_fetch_queue_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        fetch_read,
  output logic [31:0] fetch_address,
  input  logic [31:0] fetch_data,
  input  logic [31:0] fetch_data_2,
  output logic        out_valid,
  output logic        out_valid_2,
  output logic [31:0] out_inst,
  output logic [31:0] out_inst_2,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_2,
  input  logic [1:0]  pop_count
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int PTR_BITS = PTR_W + 1;
  localparam int CNT_W    = PTR_W + 3;

  logic [PTR_BITS-1:0] head_q, head_d, tail_q, tail_d, count;
  Word_t               pc_q, pc_d, req_pc_q, req_pc_d, fetch_pc;
  logic                req_valid_q, req_valid_d;
  logic                resp_valid, bypass, wr_en, wr_en_2;
  logic [1:0]          pop, buf_pop, push_n;
  logic [CNT_W-1:0]    avail, issue_level;
  FetchEntry_t         resp_entry, resp_entry_2, wr_entry, rd_entry, rd_entry_2;

  always_comb begin
    count             = tail_q - head_q;
    resp_valid        = req_valid_q && !flush;
    resp_entry.pc     = req_pc_q;
    resp_entry.inst   = fetch_data;
    resp_entry_2.pc   = req_pc_q + 32'd4;
    resp_entry_2.inst = fetch_data_2;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = resp_valid && (count == '0);
`else
    bypass = 1'b0;
`endif
    // In bypass the arriving pair is what decode sees; words it takes are never written.
    avail    = bypass ? CNT_W'(2) : CNT_W'(count);
    pop      = (CNT_W'(pop_count) > avail) ? avail[1:0] : pop_count;
    buf_pop  = bypass ? 2'd0 : pop;
    push_n   = !resp_valid ? 2'd0 : (bypass ? 2'd2 - pop : 2'd2);
    wr_en    = push_n != 2'd0;
    wr_en_2  = push_n == 2'd2;
    wr_entry = (bypass && pop == 2'd1) ? resp_entry_2 : resp_entry;

    issue_level   = CNT_W'(count) + (req_valid_q ? CNT_W'(2) : '0) - CNT_W'(pop) + CNT_W'(2);
    fetch_read    = flush || (issue_level <= CNT_W'(DEPTH));
    fetch_pc      = flush ? redirect_pc : pc_q;
    fetch_address = {2'b00, fetch_pc[31:2]};
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = req_valid_q;
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      pc_d        = redirect_pc + 32'd8;
      req_pc_d    = redirect_pc;
      req_valid_d = 1'b1;
    end else begin
      head_d      = head_q + PTR_BITS'(buf_pop);
      tail_d      = tail_q + PTR_BITS'(push_n);
      req_valid_d = fetch_read;
      if (fetch_read) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + 32'd8;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  fetch_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_en_2    (wr_en_2),
    .wr_idx     (tail_q[PTR_W-1:0]),
    .wr_entry   (wr_entry),
    .wr_entry_2 (resp_entry_2),
    .rd_idx     (head_q[PTR_W-1:0]),
    .rd_entry   (rd_entry),
    .rd_entry_2 (rd_entry_2)
  );

  always_comb begin
    out_valid   = avail != '0;
    out_valid_2 = avail >= CNT_W'(2);
    if (bypass) begin
      out_inst   = resp_entry.inst;
      out_pc     = resp_entry.pc;
      out_inst_2 = resp_entry_2.inst;
      out_pc_2   = resp_entry_2.pc;
    end else begin
      out_inst   = rd_entry.inst;
      out_pc     = rd_entry.pc;
      out_inst_2 = rd_entry_2.inst;
      out_pc_2   = rd_entry_2.pc;
    end
  end

endmodule
